// File: rtl/mem_access_unit_pkg.sv
// Shared types for the LC-3b MEM-stage access unit: opcodes, FSM states, lane enables.
package mem_access_unit_pkg;

    typedef enum logic [3:0] {
        OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB  = 4'h3,
        OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR  = 4'h7,
        OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI  = 4'hB,
        OP_JMP = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
    } lc3b_opcode_t;

    typedef enum logic [1:0] {IDLE, PTR, ACCESS, DONE} mau_state_t;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_byte_op(input logic [3:0] op);
        return (op == OP_LDB) || (op == OP_STB);
    endfunction

endpackage

// File: rtl/mem_access_unit_byte_align.sv
// Byte-lane steering: lane enables, store-byte replication and load-byte zero-extension.
module mem_byte_align
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  opcode_i,
    input  logic        addr0_i,
    input  logic [15:0] store_data_i,
    input  logic [15:0] read_data_i,
    output logic [1:0]  byte_enable_o,
    output logic [15:0] store_data_o,
    output logic [15:0] load_data_o
);

    logic byte_op;

    always_comb begin
        byte_op       = is_byte_op(opcode_i);
        byte_enable_o = BE_WORD;
        store_data_o  = store_data_i;
        load_data_o   = read_data_i;
        if (byte_op) begin
            byte_enable_o = addr0_i ? BE_HI : BE_LO;
            store_data_o  = {store_data_i[7:0], store_data_i[7:0]};
            load_data_o   = addr0_i ? {8'h00, read_data_i[15:8]} : {8'h00, read_data_i[7:0]};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer: word/byte loads and stores plus two-access LDI/STI.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic [3:0]        opcode,
    input  logic              mem2_read,
    input  logic              mem2_write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [1:0]        dmem_byte_enable,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata_out
);

    mau_state_t        state_q;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q, ptr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              read_q;

    logic              start;
    logic [3:0]        sel_op;
    logic [ADDR_W-1:0] sel_addr, acc_addr;
    logic [DATA_W-1:0] sel_data, al_wdata, al_rdata;
    logic [1:0]        al_be;

    assign start = valid_in & (mem2_read | mem2_write);
    assign stall = ((state_q == IDLE) & start) | (state_q == PTR) | (state_q == ACCESS);

    // Request outputs are registered, so the access parameters are computed from
    // whatever source is becoming authoritative on the edge that enters the state.
    always_comb begin
        sel_op   = op_q;
        sel_data = wdata_q;
        sel_addr = is_indirect(op_q) ? ptr_q : addr_q;
        if (state_q == IDLE) begin
            sel_op   = opcode;
            sel_data = wdata_in;
            sel_addr = addr_in;
        end else if (state_q == PTR) begin
            sel_addr = dmem_rdata;
        end
        acc_addr = is_byte_op(sel_op) ? sel_addr : {sel_addr[ADDR_W-1:1], 1'b0};
    end

    mem_byte_align u_align (
        .opcode_i      (sel_op),
        .addr0_i       (sel_addr[0]),
        .store_data_i  (sel_data),
        .read_data_i   (dmem_rdata),
        .byte_enable_o (al_be),
        .store_data_o  (al_wdata),
        .load_data_o   (al_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            op_q             <= '0;
            addr_q           <= '0;
            ptr_q            <= '0;
            wdata_q          <= '0;
            read_q           <= 1'b0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= '0;
            dmem_wdata       <= '0;
            dmem_byte_enable <= '0;
            done             <= 1'b0;
            rdata_out        <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: if (start) begin
                    op_q         <= opcode;
                    addr_q       <= addr_in;
                    wdata_q      <= wdata_in;
                    read_q       <= mem2_read;
                    dmem_address <= acc_addr;
                    if (is_indirect(opcode)) begin
                        state_q          <= PTR;
                        dmem_read        <= 1'b1;
                        dmem_byte_enable <= BE_WORD;
                    end else begin
                        state_q          <= ACCESS;
                        dmem_read        <= mem2_read;
                        dmem_write       <= ~mem2_read;
                        dmem_byte_enable <= al_be;
                        dmem_wdata       <= al_wdata;
                    end
                end
                PTR: if (dmem_resp) begin
                    ptr_q            <= dmem_rdata;
                    state_q          <= ACCESS;
                    dmem_read        <= read_q;
                    dmem_write       <= ~read_q;
                    dmem_address     <= acc_addr;
                    dmem_byte_enable <= al_be;
                    dmem_wdata       <= al_wdata;
                end
                ACCESS: if (dmem_resp) begin
                    if (read_q) rdata_out <= al_rdata;
                    state_q          <= DONE;
                    done             <= 1'b1;
                    dmem_read        <= 1'b0;
                    dmem_write       <= 1'b0;
                    dmem_address     <= '0;
                    dmem_wdata       <= '0;
                    dmem_byte_enable <= '0;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a latency-programmable memory responder.
module tb_mem_access_unit;

    localparam logic [3:0] LDB = 4'h2, STB = 4'h3, LDR = 4'h6, LDI = 4'hA, STI = 4'hB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in, mem2_read, mem2_write;
    logic [3:0]  opcode;
    logic [15:0] addr_in, wdata_in;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read, dmem_write, stall, done;
    logic [15:0] dmem_address, dmem_wdata, rdata_out;
    logic [1:0]  dmem_byte_enable;

    mem_access_unit #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .opcode(opcode),
        .mem2_read(mem2_read), .mem2_write(mem2_write), .addr_in(addr_in),
        .wdata_in(wdata_in), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
        .stall(stall), .done(done), .rdata_out(rdata_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word-addressed memory model and access log
    logic [15:0] mem [logic [15:0]];
    logic [15:0] log_addr [64];
    logic [15:0] log_wd   [64];
    logic [1:0]  log_be   [64];
    logic        log_wr   [64];
    int n_acc = 0, cnt = 0, lat_a = 1, lat_b = 1, b_acc = 0;
    bit inject = 0;
    logic was;
    logic [15:0] wa, word;

    always @(negedge clk) begin
        was = dmem_resp;
        dmem_resp = 1'b0;
        if (was) cnt = 0;
        if (inject && !was) begin
            dmem_resp  = 1'b1;
            dmem_rdata = 16'hFFFF;
        end else if (!inject && reset_n && (dmem_read || dmem_write)) begin
            cnt++;
            if (cnt >= (((n_acc - b_acc) == 0) ? lat_a : lat_b)) begin
                wa = {dmem_address[15:1], 1'b0};
                word = mem.exists(wa) ? mem[wa] : 16'h0000;
                log_addr[n_acc % 64] = dmem_address;
                log_wd[n_acc % 64]   = dmem_wdata;
                log_be[n_acc % 64]   = dmem_byte_enable;
                log_wr[n_acc % 64]   = dmem_write;
                n_acc++;
                if (dmem_write) begin
                    if (dmem_byte_enable[1]) word[15:8] = dmem_wdata[15:8];
                    if (dmem_byte_enable[0]) word[7:0]  = dmem_wdata[7:0];
                    mem[wa] = word;
                end else begin
                    dmem_rdata = word;
                end
                dmem_resp = 1'b1;
            end
        end else begin
            cnt = 0;
        end
    end

    int stall_cyc = 0, rd_cyc = 0, wr_cyc = 0, done_cnt = 0;
    int b_stall, b_rd, b_wr, b_done;

    always @(negedge clk) begin
        if (stall)      stall_cyc++;
        if (dmem_read)  rd_cyc++;
        if (dmem_write) wr_cyc++;
        if (done)       done_cnt++;
    end

    task automatic run_op(input string tag, input logic [3:0] op, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] wd, input int la, input int lb);
        bit seen;
        seen = 0;
        @(posedge clk); #1;
        lat_a = la; lat_b = lb;
        b_acc = n_acc; b_stall = stall_cyc; b_rd = rd_cyc; b_wr = wr_cyc; b_done = done_cnt;
        valid_in = 1'b1; opcode = op; mem2_read = rd; mem2_write = wr; addr_in = a; wdata_in = wd;
        @(posedge clk); #1;
        // Scramble inputs so only the latched copies can produce correct results
        valid_in = 1'b0; mem2_read = 1'b0; mem2_write = 1'b0;
        opcode = 4'h1; addr_in = 16'hDEAD; wdata_in = 16'hCAFE;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_stall_in_done"}, stall, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; valid_in = 0; mem2_read = 0; mem2_write = 0;
        opcode = 4'h0; addr_in = '0; wdata_in = '0; dmem_resp = 0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_read", dmem_read, 0);
        check("rst_write", dmem_write, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_addr", dmem_address, 16'h0000);
        check("rst_be", dmem_byte_enable, 2'b00);
        check("rst_rdata", rdata_out, 16'h0000);
        reset_n = 1'b1;

        mem[16'h3004] = 16'hBEEF;
        mem[16'h2000] = 16'h80F0;
        mem[16'h4000] = 16'h5002;
        mem[16'h5002] = 16'h1234;

        run_op("ldr", LDR, 1, 0, 16'h3004, 16'h0000, 2, 2);
        check("ldr_rdata", rdata_out, 16'hBEEF);
        check("ldr_nacc", n_acc - b_acc, 1);
        check("ldr_addr", log_addr[b_acc % 64], 16'h3004);
        check("ldr_be", log_be[b_acc % 64], 2'b11);
        check("ldr_is_rd", log_wr[b_acc % 64], 0);
        check("ldr_rd_cyc", rd_cyc - b_rd, 2);
        check("ldr_stall_cyc", stall_cyc - b_stall, 3);
        check("ldr_done_cnt", done_cnt - b_done, 1);

        run_op("stb", STB, 0, 1, 16'h2001, 16'h12A5, 1, 1);
        check("stb_rdata_kept", rdata_out, 16'hBEEF);
        check("stb_is_wr", log_wr[b_acc % 64], 1);
        check("stb_addr", log_addr[b_acc % 64], 16'h2001);
        check("stb_wdata", log_wd[b_acc % 64], 16'hA5A5);
        check("stb_be", log_be[b_acc % 64], 2'b10);
        check("stb_wr_cyc", wr_cyc - b_wr, 1);

        mem[16'h2000] = 16'h80F0;
        run_op("ldb_lo", LDB, 1, 0, 16'h2000, 16'h0000, 1, 1);
        check("ldb_lo_be", log_be[b_acc % 64], 2'b01);
        check("ldb_lo_rdata", rdata_out, 16'h00F0);
        run_op("ldb_hi", LDB, 1, 0, 16'h2001, 16'h0000, 3, 3);
        check("ldb_hi_be", log_be[b_acc % 64], 2'b10);
        check("ldb_hi_addr", log_addr[b_acc % 64], 16'h2001);
        check("ldb_hi_rdata", rdata_out, 16'h0080);

        run_op("ldi", LDI, 1, 0, 16'h4000, 16'h0000, 2, 3);
        check("ldi_nacc", n_acc - b_acc, 2);
        check("ldi_addr0", log_addr[b_acc % 64], 16'h4000);
        check("ldi_addr1", log_addr[(b_acc + 1) % 64], 16'h5002);
        check("ldi_rdata", rdata_out, 16'h1234);
        check("ldi_done_cnt", done_cnt - b_done, 1);
        check("ldi_stall_cyc", stall_cyc - b_stall, 6);
        check("ldi_rd_cyc", rd_cyc - b_rd, 5);

        mem[16'h4000] = 16'h6000;
        run_op("sti", STI, 0, 1, 16'h4000, 16'h00FF, 1, 1);
        check("sti_nacc", n_acc - b_acc, 2);
        check("sti_ptr_rd", log_wr[b_acc % 64], 0);
        check("sti_ptr_addr", log_addr[b_acc % 64], 16'h4000);
        check("sti_wr", log_wr[(b_acc + 1) % 64], 1);
        check("sti_wr_addr", log_addr[(b_acc + 1) % 64], 16'h6000);
        check("sti_wr_data", log_wd[(b_acc + 1) % 64], 16'h00FF);
        check("sti_wr_be", log_be[(b_acc + 1) % 64], 2'b11);
        check("sti_mem", mem[16'h6000], 16'h00FF);
        check("sti_rdata_kept", rdata_out, 16'h1234);

        // Both read and write asserted, odd word address: read wins, bit0 cleared
        mem[16'h3004] = 16'h5A5A;
        run_op("rw_both", LDR, 1, 1, 16'h3005, 16'h7777, 1, 1);
        check("rw_both_is_rd", log_wr[b_acc % 64], 0);
        check("rw_both_addr", log_addr[b_acc % 64], 16'h3004);
        check("rw_both_rdata", rdata_out, 16'h5A5A);

        // Abort mid-ACCESS with asynchronous reset
        @(posedge clk); #1;
        lat_a = 20; lat_b = 20; b_acc = n_acc;
        valid_in = 1; opcode = LDR; mem2_read = 1; addr_in = 16'h3004;
        @(posedge clk); #1;
        valid_in = 0; mem2_read = 0;
        @(posedge clk); #1;
        check("abort_pre_read", dmem_read, 1);
        reset_n = 1'b0;
        #1;
        check("abort_read", dmem_read, 0);
        check("abort_addr", dmem_address, 16'h0000);
        check("abort_be", dmem_byte_enable, 2'b00);
        check("abort_stall", stall, 0);
        check("abort_rdata", rdata_out, 16'h0000);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Noise: spurious responses in IDLE and mem2_read without valid_in
        b_done = done_cnt;
        inject = 1; mem2_read = 1; valid_in = 0; opcode = LDR; addr_in = 16'h3004;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("noise_stall", stall, 0);
            check("noise_read", dmem_read, 0);
        end
        @(posedge clk); #1;
        inject = 0; mem2_read = 0;
        repeat (2) @(posedge clk);
        #1;
        check("noise_done_cnt", done_cnt - b_done, 0);
        check("noise_rdata", rdata_out, 16'h0000);

        run_op("recover", LDR, 1, 0, 16'h3004, 16'h0000, 1, 1);
        check("recover_rdata", rdata_out, 16'h5A5A);
        check("recover_nacc", n_acc - b_acc, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the lc3b_control word produced at decode.
- Turns ctrl.mem2_read / ctrl.mem2_write plus the EX/MEM address and store data into handshaked data-memory requests.
- Handles the byte accesses (LDB/STB) and the two-access indirect ops (LDI/STI).
- Holds the pipeline with a stall signal until the data is returned or written.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width; fixed at 16 for LC-3b

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- valid_in  in  1  EX/MEM latch holds a live instruction
- opcode  in  4  ctrl.opcode (lc3b_opcode)
- mem2_read  in  1  ctrl.mem2_read
- mem2_write  in  1  ctrl.mem2_write
- addr_in  in  16  effective address from ALU
- wdata_in  in  16  store source register value
- dmem_resp  in  1  memory completion strobe, one cycle
- dmem_rdata  in  16  memory read data, valid with dmem_resp
- dmem_read  out  1  read request, level-held until resp
- dmem_write  out  1  write request, level-held until resp
- dmem_address  out  16  request address
- dmem_wdata  out  16  write data
- dmem_byte_enable  out  2  lane enables, [1]=high byte
- stall  out  1  freeze IF/ID/EX/MEM latches
- done  out  1  one-cycle completion pulse
- rdata_out  out  16  load result to MEM/WB

Behaviour:
- Reset: one clock (clk); async active-low reset_n.
  - state=IDLE.
  - dmem_read, dmem_write, done, stall = 0.
  - dmem_address, dmem_wdata, rdata_out, ptr_reg = 0; dmem_byte_enable = 2'b00.
- Start condition: start = valid_in & (mem2_read | mem2_write), sampled only in IDLE.
- Read/write priority: mem2_read=mem2_write=1 is treated as a read.
- stall = start (combinational, in IDLE) | state in {PTR, ACCESS}. stall is 0 in DONE.
- States:
  - IDLE:
    - opcode ldi/sti with start -> PTR; other starts -> ACCESS.
    - On start, latch addr_in, wdata_in, opcode, rw into internal registers.
  - PTR:
    - dmem_read=1, dmem_address={addr[15:1],0}, byte_enable=11.
    - On dmem_resp: ptr_reg<=dmem_rdata; go to ACCESS.
  - ACCESS:
    - Address is ptr_reg if indirect, else the latched addr.
    - Word op: address bit0 forced to 0, byte_enable=11, dmem_wdata=data.
    - STB: dmem_wdata={data[7:0],data[7:0]}, byte_enable = addr[0] ? 10 : 01; address passed unmodified.
    - LDB: byte_enable as for STB.
    - On dmem_resp: rdata_out<=aligned data; go to DONE.
      - Word load: aligned data = dmem_rdata.
      - LDB: aligned data = zero-extended dmem_rdata[15:8] if addr[0], else dmem_rdata[7:0].
      - Store: rdata_out unchanged.
  - DONE:
    - done=1, stall=0; pipeline advances this cycle.
    - Next state IDLE unconditionally; a start one cycle later is a new instruction.
- Requests: dmem_read/dmem_write/address/wdata/byte_enable are Moore outputs, stable for the whole PTR/ACCESS dwell.
  - Dropped the cycle after dmem_resp.
  - Zero in IDLE and DONE.
- Latency: start at cycle t; response k cycles after request entry (k>=1).
  - Non-indirect op: done at t+k+1.
  - Indirect op: done at t+k1+k2+1.
- dmem_resp in IDLE/DONE: ignored.
- Inputs are ignored outside IDLE; the latched copies are authoritative.
- reset_n low mid-transaction: immediate return to IDLE; outputs to reset values; the pending request is abandoned.

Decomposition:
- lc3b_types gains:
  - mau_state_t enum {IDLE, PTR, ACCESS, DONE}
  - Constants BE_WORD=2'b11, BE_LO=2'b01, BE_HI=2'b10
- One sub-module: mem_byte_align (combinational).
  - Inputs: opcode, addr[0], store data, read data.
  - Outputs: byte_enable, store lane replication, load zero-extension.

Test Plan:
- LDR, addr_in=16'h3004, memory returns 16'hBEEF after 2 cycles -> dmem_read high 2 cycles at 16'h3004, BE=11; done pulse; rdata_out=16'hBEEF; stall high 3 cycles.
- STB, addr_in=16'h2001, wdata_in=16'h12A5 -> dmem_write, address 16'h2001, dmem_wdata=16'hA5A5, BE=10; no rdata_out change.
- LDB, addr_in=16'h2000, memory returns 16'h80F0 -> BE=01; rdata_out=16'h00F0.
  - Repeat with addr_in=16'h2001 -> rdata_out=16'h0080.
- LDI, addr_in=16'h4000, mem[4000]=16'h5002, mem[5002]=16'h1234 -> two reads, 16'h4000 then 16'h5002; rdata_out=16'h1234; exactly one done pulse.
- STI, addr_in=16'h4000, mem[4000]=16'h6000, wdata_in=16'h00FF -> read at 16'h4000, then write 16'h00FF at 16'h6000, BE=11.
- Abort and noise: reset_n low during an ACCESS wait -> outputs zero asynchronously, state IDLE; spurious dmem_resp in IDLE and valid_in=0 with mem2_read=1 -> no request, stall=0.
